pipe_stage_regs: RTL and testbench

Parametrised elastic pipeline stage register: the general successor to the fixed per-stage latch banks between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries LANES independent WIDTH-bit fields (IR, PC+8, operands, immediate, …) under a valid/ready handshake, so a stage can stall its upstream without external hold logic. It also supports a synchronous flush that inserts a zero bubble (all-zero IR = nop) and counts back-pressure cycles for performance debug.

---
 rtl/pipe_stage_regs.sv | 134 +++++++++++++
 tb/tb_pipe_stage_regs.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: elastic valid/ready pipeline stage carrying LANES x WIDTH-bit fields,
// with synchronous flush and saturating back-pressure counter. Optional skid: PIPE_SKID_EN.
`default_nettype none

module pipe_stage_regs #(
  parameter int LANES = 5,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int DW = LANES * WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    main_q, main_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer_in, xfer_out;

`ifdef PIPE_SKID_EN
  logic [DW-1:0]    skid_q, skid_d;
  logic             in_ready_q;

  // Registered ready breaks the combinational out_ready -> in_ready path.
  assign in_ready = in_ready_q;
`else
  assign in_ready = ~out_valid | out_ready;
`endif

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign stall_cnt = cnt_q;
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
`ifdef PIPE_SKID_EN
      skid_d  = '0;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            main_d = in_data;
`ifdef PIPE_SKID_EN
          end else if (xfer_in) begin
            state_d = TWO;
            skid_d  = in_data;
`endif
          end else if (xfer_out) begin
            // Emptied register is zeroed so out_data reads 0 while invalid.
            state_d = EMPTY;
            main_d  = '0;
          end
        end
`ifdef PIPE_SKID_EN
        TWO: begin
          if (xfer_out) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
`endif
        default: begin
          state_d = EMPTY;
          main_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && !flush && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      skid_q     <= skid_d;
      in_ready_q <= (state_d != TWO);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_regs.sv
// Directed self-checking bench for pipe_stage_regs (both PIPE_SKID_EN builds).
`default_nettype none

module tb_pipe_stage_regs;

  localparam int LANES = 5;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int DW    = LANES * WIDTH;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks;
  int n_fails;

  pipe_stage_regs #(.LANES(LANES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] beat(input int n);
    logic [DW-1:0] b;
    b = '0;
    for (int k = 0; k < LANES; k++) b[k*WIDTH +: WIDTH] = 32'(k * 16 + n);
    return b;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  logic [DW-1:0] acc_q[$];
  logic [DW-1:0] a5;
  int            acc_n;
  int            guard;

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    check("rst_valid", DW'(out_valid), DW'(1'b0));
    check("rst_data", out_data, '0);
    check("rst_stall", DW'(stall_cnt), '0);
    check("rst_ready", DW'(in_ready), DW'(1'b1));
    step();
    reset = 1'b1;

    // Streaming at full rate
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int n = 0; n < 8; n++) begin
      in_data = beat(n);
      step();
      check("stream_valid", DW'(out_valid), DW'(1'b1));
      check("stream_data", out_data, beat(n));
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_valid", DW'(out_valid), DW'(1'b0));
    check("stream_drain_data", out_data, '0);
    check("stream_stall", DW'(stall_cnt), '0);

    // Back-pressure: first edge loads from empty, then 4 stalled cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc_n     = 0;
    for (int c = 0; c < 5; c++) begin
      in_data = beat(32 + acc_n);
      if (in_ready) begin
        acc_q.push_back(in_data);
        acc_n++;
      end
      step();
    end
    in_valid = 1'b0;
`ifdef PIPE_SKID_EN
    check("bp_accepted", DW'(acc_n), DW'(2));
`else
    check("bp_accepted", DW'(acc_n), DW'(1));
`endif
    check("bp_ready", DW'(in_ready), DW'(1'b0));
    check("bp_stall", DW'(stall_cnt), DW'(4));
    out_ready = 1'b1;
    while (acc_q.size() > 0) begin
      check("bp_drain_valid", DW'(out_valid), DW'(1'b1));
      check("bp_drain_data", out_data, acc_q.pop_front());
      step();
    end
    check("bp_empty_valid", DW'(out_valid), DW'(1'b0));
    check("bp_stall_hold", DW'(stall_cnt), DW'(4));

    // Flush from full occupancy with a competing input beat
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    guard     = 0;
    while (in_ready && guard < 8) begin
      in_data = beat(64 + guard);
      step();
      guard++;
    end
`ifdef PIPE_SKID_EN
    check("fl_fill", DW'(guard), DW'(2));
`else
    check("fl_fill", DW'(guard), DW'(1));
`endif
    flush   = 1'b1;
    in_data = beat(119);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", DW'(out_valid), DW'(1'b0));
    check("fl_data", out_data, '0);
    check("fl_ready", DW'(in_ready), DW'(1'b1));
`ifdef PIPE_SKID_EN
    check("fl_stall", DW'(stall_cnt), DW'(1));
`else
    check("fl_stall", DW'(stall_cnt), DW'(0));
`endif
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("fl_no_ghost", DW'(out_valid), DW'(1'b0));
    end

    // Counter saturation
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = beat(5);
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 14) check("sat_14", DW'(stall_cnt), DW'(14));
      if (c == 15) check("sat_15", DW'(stall_cnt), DW'(15));
    end
    check("sat_hold", DW'(stall_cnt), DW'(15));
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("sat_after_flush", DW'(stall_cnt), DW'(15));

    // Asynchronous reset between edges
    in_valid = 1'b1;
    in_data  = beat(9);
    step();
    in_valid = 1'b0;
    check("ar_pre_valid", DW'(out_valid), DW'(1'b1));
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid", DW'(out_valid), DW'(1'b0));
    check("ar_data", out_data, '0);
    check("ar_stall", DW'(stall_cnt), '0);
    check("ar_ready", DW'(in_ready), DW'(1'b1));
    step();
    reset = 1'b1;

    // Simultaneous in/out while holding one beat
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = beat(48);
    step();
    check("sim_first", out_data, beat(48));
    a5      = {LANES{32'hA5A5A5A5}};
    in_data = a5;
    step();
    in_valid = 1'b0;
    check("sim_valid", DW'(out_valid), DW'(1'b1));
    check("sim_data", out_data, a5);
    check("sim_ready", DW'(in_ready), DW'(1'b1));
    step();
    check("sim_one_left", DW'(out_valid), DW'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
